// File: rtl/tri_state_bus_arbiter_pkg.sv
// Shared definitions for the tri-state bus arbiter.
//   - FSM state encoding (IDLE / DRIVE / TURN)
//   - rr_pick: round-robin pick over a request vector of up to RR_MAX bits
package tri_bus_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_TURN  = 2'd2;

    // Widest request vector rr_pick can handle; callers zero-extend into it.
    localparam int unsigned RR_MAX   = 32;
    localparam int unsigned RR_IDX_W = $clog2(RR_MAX);

    // Returns a one-hot winner: the first set bit of req[n-1:0] found when
    // scanning upward from ptr and wrapping from n-1 back to 0. Zero if no
    // bit is set. ptr must be below n.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                   input int unsigned     ptr,
                                                   input int unsigned     n);
        logic [RR_MAX-1:0]   win;
        logic                found;
        int unsigned         sum;
        logic [RR_IDX_W-1:0] idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                sum = ptr + k;
                if (sum >= n) begin
                    sum = sum - n;
                end
                idx = RR_IDX_W'(sum);
                if (!found && req[idx]) begin
                    win[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick.
// Ports:
//   req_i        per-master request vector
//   ptr_i        highest-priority index for this pick
//   any_req_o    1 when any request is set
//   win_onehot_o one-hot winner (zero when no request)
//   win_idx_o    binary index of the winner (0 when no request)
module rr_arbiter_core
    import tri_bus_pkg::*;
#(
    parameter int unsigned  N_MASTERS = 4,
    localparam int unsigned IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 any_req_o,
    output logic [N_MASTERS-1:0] win_onehot_o,
    output logic [IDX_W-1:0]     win_idx_o
);

    always_comb begin
        any_req_o    = |req_i;
        win_onehot_o = N_MASTERS'(rr_pick(RR_MAX'(req_i), 32'(ptr_i), N_MASTERS));
        win_idx_o    = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (win_onehot_o[i]) begin
                win_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tri_state_bus_arbiter.sv
// Registered tri-state data bus shared by N_MASTERS sources with round-robin
// arbitration and a TURN_CYCLES-long Z gap between any two owners.
// Optional feature macro: BUS_TIMEOUT_EN (limits each tenure to MAX_HOLD cycles).
// Ports:
//   clk_in        clock, all logic on posedge
//   rst_n_in      synchronous active-low reset
//   req_in        per-master level request
//   data_in       packed source data, master i at [i*DATA_W +: DATA_W]
//   grant_out     registered one-hot grant
//   owner_out     index of current owner, valid when bus_valid_out=1
//   bus_valid_out 1 while the bus is driven
//   data_bus_io   shared bus, data_q when driven, else Z
//   bus_rd_out    registered copy of data_bus_io
module tri_state_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int unsigned  DATA_W      = 8,
    parameter int unsigned  N_MASTERS   = 4,
    parameter int unsigned  TURN_CYCLES = 1,
    parameter int unsigned  MAX_HOLD    = 16,
    localparam int unsigned IDX_W       = $clog2(N_MASTERS)
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [N_MASTERS-1:0]        req_in,
    input  logic [N_MASTERS*DATA_W-1:0] data_in,
    output logic [N_MASTERS-1:0]        grant_out,
    output logic [IDX_W-1:0]            owner_out,
    output logic                        bus_valid_out,
    inout  wire  [DATA_W-1:0]           data_bus_io,
    output logic [DATA_W-1:0]           bus_rd_out
);

    localparam int unsigned TC_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    if (N_MASTERS < 2 || N_MASTERS > RR_MAX || TURN_CYCLES < 1 || MAX_HOLD < 1)
    begin : g_bad_params
        $error("tri_state_bus_arbiter: parameter out of range");
    end

    state_t              state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                oe_q, oe_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   bus_rd_q;
    logic [TC_W-1:0]     turn_cnt_q, turn_cnt_d;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TEN_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [TEN_W-1:0]    tenure_q, tenure_d;
`endif

    logic                any_req;
    logic [N_MASTERS-1:0] win_onehot;
    logic [IDX_W-1:0]    win_idx;
    logic [DATA_W-1:0]   src [N_MASTERS];

    always_comb begin
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            src[i] = data_in[i*DATA_W +: DATA_W];
        end
    end

    rr_arbiter_core #(
        .N_MASTERS (N_MASTERS)
    ) u_rr_core (
        .req_i        (req_in),
        .ptr_i        (ptr_q),
        .any_req_o    (any_req),
        .win_onehot_o (win_onehot),
        .win_idx_o    (win_idx)
    );

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            oe_q       <= 1'b0;
            data_q     <= '0;
            bus_rd_q   <= '0;
            turn_cnt_q <= '0;
`ifdef BUS_TIMEOUT_EN
            tenure_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            data_q     <= data_d;
            bus_rd_q   <= data_bus_io;
            turn_cnt_q <= turn_cnt_d;
`ifdef BUS_TIMEOUT_EN
            tenure_q   <= tenure_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        logic arb;
        logic release_bus;
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        oe_d        = oe_q;
        data_d      = data_q;
        turn_cnt_d  = turn_cnt_q;
`ifdef BUS_TIMEOUT_EN
        tenure_d    = tenure_q;
`endif
        arb         = 1'b0;
        release_bus = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arb = 1'b1;
            end
            ST_DRIVE: begin
                data_d      = src[owner_q];
                release_bus = !req_in[owner_q];
`ifdef BUS_TIMEOUT_EN
                tenure_d = tenure_q + TEN_W'(1);
                // Last permitted driven cycle: force the bus free.
                if (tenure_q == TEN_W'(MAX_HOLD - 1)) begin
                    release_bus = 1'b1;
                end
`endif
                if (release_bus) begin
                    state_d    = ST_TURN;
                    grant_d    = '0;
                    oe_d       = 1'b0;
                    turn_cnt_d = '0;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == TC_W'(TURN_CYCLES - 1)) begin
                    arb = 1'b1;
                end else begin
                    turn_cnt_d = turn_cnt_q + TC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                oe_d    = 1'b0;
            end
        endcase

        if (arb) begin
            if (any_req) begin
                state_d = ST_DRIVE;
                grant_d = win_onehot;
                owner_d = win_idx;
                oe_d    = 1'b1;
                data_d  = src[win_idx];
                // Last winner drops to lowest priority for the next pick.
                ptr_d   = (win_idx == IDX_W'(N_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
`ifdef BUS_TIMEOUT_EN
                tenure_d = '0;
`endif
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Outputs
    always_comb begin
        grant_out     = grant_q;
        owner_out     = owner_q;
        bus_valid_out = oe_q;
        bus_rd_out    = bus_rd_q;
    end

    assign data_bus_io = oe_q ? data_q : 'z;

endmodule

// File: tb/tb_tri_state_bus_arbiter.sv
module tb_tri_state_bus_arbiter;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned N        = 4;
    localparam int unsigned TURN     = 1;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned IDX_W    = 2;

    logic                clk_in = 1'b0;
    logic                rst_n_in;
    logic [N-1:0]        req_in;
    logic [N*DATA_W-1:0] data_in;
    logic [N-1:0]        grant_out;
    logic [IDX_W-1:0]    owner_out;
    logic                bus_valid_out;
    logic [DATA_W-1:0]   bus_rd_out;
    wire  [DATA_W-1:0]   data_bus_io;

    // Bench keeper: drives a random pattern whenever the bus should be idle,
    // so any unexpected DUT drive shows up as a corrupted bus value.
    logic                keep_en;
    logic [DATA_W-1:0]   keep_val;
    assign data_bus_io = keep_en ? keep_val : 'z;

    always #5 clk_in = ~clk_in;

    tri_state_bus_arbiter #(
        .DATA_W      (DATA_W),
        .N_MASTERS   (N),
        .TURN_CYCLES (TURN),
        .MAX_HOLD    (MAX_HOLD)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .req_in        (req_in),
        .data_in       (data_in),
        .grant_out     (grant_out),
        .owner_out     (owner_out),
        .bus_valid_out (bus_valid_out),
        .data_bus_io   (data_bus_io),
        .bus_rd_out    (bus_rd_out)
    );

    // Reference model: owner (-1 = nobody), Z cycles still to wait, priority
    // start index, driven cycles of the current tenure, registered data/readback.
    int                errors;
    int                checks;
    int                m_owner;
    int                m_gap;
    int                m_ptr;
    int                m_ten;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hold_limit(input int ten);
`ifdef BUS_TIMEOUT_EN
        return ten >= MAX_HOLD;
`else
        return (ten < 0);
`endif
    endfunction

    task automatic model_step(input logic rst_n, input logic [N-1:0] req,
                              input logic [N*DATA_W-1:0] data);
        logic [DATA_W-1:0] cur_bus;
        cur_bus = (m_owner >= 0) ? m_data : keep_val;
        if (!rst_n) begin
            m_owner = -1; m_gap = 0; m_ptr = 0; m_ten = 0; m_data = '0; m_rd = '0;
        end else begin
            m_rd = cur_bus;
            if (m_owner >= 0) begin
                m_ten++;
                if (!req[m_owner] || hold_limit(m_ten)) begin
                    m_owner = -1;
                    m_gap   = TURN;
                end else begin
                    m_data = data[m_owner*DATA_W +: DATA_W];
                end
            end else if (m_gap > 1) begin
                m_gap--;
            end else begin
                m_gap = 0;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (m_owner < 0 && req[idx]) m_owner = idx;
                end
                if (m_owner >= 0) begin
                    m_ptr  = (m_owner + 1) % N;
                    m_data = data[m_owner*DATA_W +: DATA_W];
                    m_ten  = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] exp_grant;
        exp_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        chk("grant", grant_out, exp_grant);
        chk("valid", bus_valid_out, m_owner >= 0);
        if (m_owner >= 0) chk("owner", owner_out, m_owner);
        chk("bus", data_bus_io, (m_owner >= 0) ? m_data : keep_val);
        chk("bus_rd", bus_rd_out, m_rd);
        chk("onehot0", $onehot0(grant_out), 1);
    endtask

    task automatic cycle(input logic rst_n, input logic [N-1:0] req,
                         input logic [N*DATA_W-1:0] data);
        rst_n_in = rst_n;
        req_in   = req;
        data_in  = data;
        @(posedge clk_in);
        model_step(rst_n, req, data);
        #1;
        keep_en  = (m_owner < 0);
        keep_val = DATA_W'($urandom);
        @(negedge clk_in);
        check_all();
    endtask

    initial begin
        logic [N*DATA_W-1:0] d;
        logic [N-1:0]        bitk;
        logic [N-1:0]        r;
        int                  held;
        int                  exp_hold;
        errors = 0; checks = 0;
        m_owner = -1; m_gap = 0; m_ptr = 0; m_ten = 0; m_data = '0; m_rd = '0;
        keep_en = 1'b1; keep_val = 8'h00;
        rst_n_in = 1'b0; req_in = '0; data_in = '0;

        // 1: reset held with all requests up
        repeat (3) cycle(1'b0, 4'hF, $urandom);
        chk("t1_grant", grant_out, 0);
        chk("t1_valid", bus_valid_out, 0);
        chk("t1_rd", bus_rd_out, 0);

        // 2: single owner
        d = $urandom; d[23:16] = 8'hA5;
        cycle(1'b1, 4'b0100, d);
        chk("t2_grant", grant_out, 4'b0100);
        chk("t2_owner", owner_out, 2);
        chk("t2_bus", data_bus_io, 8'hA5);
        cycle(1'b1, 4'b0000, d);
        chk("t2_release", bus_valid_out, 0);
        cycle(1'b1, 4'b0000, d);
        chk("t2_idle", grant_out, 0);

        // 3: round robin, each owner drops after 2 driven cycles
        cycle(1'b0, 4'h0, $urandom);
        for (int k = 0; k < 5; k++) begin
            bitk = N'(1 << (k % N));
            cycle(1'b1, 4'hF, $urandom);
            chk("t3_order", grant_out, bitk);
            cycle(1'b1, 4'hF, $urandom);
            cycle(1'b1, 4'hF & ~bitk, $urandom);
            chk("t3_gap", bus_valid_out, 0);
        end

        // 4: pointer at 3, wrap to 0 then 1
        cycle(1'b1, 4'b0100, $urandom);
        cycle(1'b1, 4'b0000, $urandom);
        cycle(1'b1, 4'b0011, $urandom);
        chk("t4_wrap", grant_out, 4'b0001);
        cycle(1'b1, 4'b0010, $urandom);
        cycle(1'b1, 4'b0010, $urandom);
        chk("t4_skip", grant_out, 4'b0010);
        cycle(1'b1, 4'b0000, $urandom);
        cycle(1'b1, 4'b0000, $urandom);

        // 5: reset mid-tenure
        d = $urandom; d[15:8] = 8'h3C;
        cycle(1'b1, 4'b0010, d);
        chk("t5_bus", data_bus_io, 8'h3C);
        cycle(1'b0, 4'hF, d);
        chk("t5_grant", grant_out, 0);
        chk("t5_valid", bus_valid_out, 0);
        cycle(1'b1, 4'hF, $urandom);
        chk("t5_prio", grant_out, 4'b0001);

        // 6: master 0 holds its request while master 1 waits
        cycle(1'b0, 4'h0, $urandom);
        held = 0;
        repeat (10) begin
            cycle(1'b1, 4'b0011, $urandom);
            if (grant_out == 4'b0001) held++;
        end
`ifdef BUS_TIMEOUT_EN
        exp_hold = MAX_HOLD;
`else
        exp_hold = 10;
`endif
        chk("t6_hold", held, exp_hold);

        // Random traffic with occasional resets
        repeat (400) begin
            r = N'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            cycle(($urandom_range(0, 49) != 0), r, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
